// File: rtl/hls_fifo_stim_src.sv
// On-board stimulus source driving two HLS ap_fifo input channels with Galois-LFSR data.
// Tracks per-channel sums of popped words and flags reads issued against an empty channel.
module hls_fifo_stim_src #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned CNT_W  = 16,
  parameter logic [31:0] SEED0  = 32'h0000_0001,
  parameter logic [31:0] SEED1  = 32'h0000_ACE1
) (
  input  logic              ap_clk,
  input  logic              ap_rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_words,
  output logic [DATA_W-1:0] D_in_0_dout,
  output logic              D_in_0_empty_n,
  input  logic              D_in_0_read,
  output logic [DATA_W-1:0] D_in_1_dout,
  output logic              D_in_1_empty_n,
  input  logic              D_in_1_read,
  output logic              busy,
  output logic              done,
  output logic [31:0]       sum_0,
  output logic [31:0]       sum_1,
  output logic              err_rd_empty
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [31:0]        Taps  = 32'h8020_0003;
  localparam logic [1:0][31:0]   Seeds = {SEED1, SEED0};

  function automatic logic [31:0] lfsr_step(input logic [31:0] l);
    return (l >> 1) ^ (l[0] ? Taps : 32'h0);
  endfunction

  state_e                   r_state, w_state_nxt;
  logic [1:0][31:0]         r_lfsr, w_lfsr_nxt, w_step;
  logic [1:0][CNT_W-1:0]    r_rem, w_rem_nxt;
  logic [1:0][DATA_W-1:0]   r_dout, w_dout_nxt;
  logic [1:0][31:0]         r_sum, w_sum_nxt;
  logic [1:0]               r_empty_n, w_empty_n_nxt;
  logic                     r_err, w_err_nxt;
  logic [1:0]               w_read, w_pop;

  assign w_read = {D_in_1_read, D_in_0_read};
  assign w_pop  = w_read & r_empty_n;

  always_comb begin
    w_state_nxt   = r_state;
    w_lfsr_nxt    = r_lfsr;
    w_rem_nxt     = r_rem;
    w_dout_nxt    = r_dout;
    w_sum_nxt     = r_sum;
    w_empty_n_nxt = r_empty_n;
    w_err_nxt     = r_err;
    for (int c = 0; c < 2; c++) begin
      w_step[c] = lfsr_step(r_lfsr[c]);
    end

    unique case (r_state)
      StIdle: begin
        if (start) begin
          w_sum_nxt = '0;
          w_err_nxt = 1'b0;
          if (num_words != '0) begin
            w_state_nxt = StRun;
            for (int c = 0; c < 2; c++) begin
              w_rem_nxt[c]     = num_words;
              w_lfsr_nxt[c]    = Seeds[c];
              w_dout_nxt[c]    = Seeds[c][DATA_W-1:0];
              w_empty_n_nxt[c] = 1'b1;
            end
          end else begin
            w_state_nxt = StDone;
          end
        end
      end
      StRun: begin
        // Both channels drained: rem and empty_n are already zero here.
        if (r_empty_n == 2'b00) begin
          w_state_nxt = StDone;
        end
        for (int c = 0; c < 2; c++) begin
          if (w_pop[c]) begin
            w_rem_nxt[c] = r_rem[c] - CNT_W'(1);
            w_sum_nxt[c] = r_sum[c] + 32'(r_dout[c]);
            // Last word keeps dout frozen on the final value.
            if (r_rem[c] == CNT_W'(1)) begin
              w_empty_n_nxt[c] = 1'b0;
            end else begin
              w_lfsr_nxt[c] = w_step[c];
              w_dout_nxt[c] = w_step[c][DATA_W-1:0];
            end
          end
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase

    if ((w_read & ~r_empty_n) != 2'b00) begin
      w_err_nxt = 1'b1;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      r_state   <= StIdle;
      r_lfsr    <= Seeds;
      r_rem     <= '0;
      r_dout    <= '0;
      r_sum     <= '0;
      r_empty_n <= '0;
      r_err     <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_lfsr    <= w_lfsr_nxt;
      r_rem     <= w_rem_nxt;
      r_dout    <= w_dout_nxt;
      r_sum     <= w_sum_nxt;
      r_empty_n <= w_empty_n_nxt;
      r_err     <= w_err_nxt;
    end
  end

  assign D_in_0_dout    = r_dout[0];
  assign D_in_1_dout    = r_dout[1];
  assign D_in_0_empty_n = r_empty_n[0];
  assign D_in_1_empty_n = r_empty_n[1];
  assign busy           = (r_state == StRun);
  assign done           = (r_state == StDone);
  assign sum_0          = r_sum[0];
  assign sum_1          = r_sum[1];
  assign err_rd_empty   = r_err;

endmodule
